// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request payload plus ack/read-data return.
interface dmem_arbiter_if #(
    parameter int unsigned AW = 6
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    be;
    logic          ack;
    logic [31:0]   rdata;

    modport master (output req, we, addr, wdata, be, input ack, rdata);
    modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for a single-port word memory.
// Partial-byte stores are done as read-modify-write.
module dmem_arbiter #(
    parameter int unsigned AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave p0,
    dmem_arbiter_if.slave p1,
    output logic          busy,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);
    localparam int unsigned DW = 32;
    localparam int unsigned NB = DW / 8;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t          state_q, state_d;
    logic            ptr_q;
    logic            port_q;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [NB-1:0]   be_q;
    logic [DW-1:0]   data_q;

    logic            any_req;
    logic            gnt;
    logic            win_we;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_wdata;
    logic [NB-1:0]   win_be;
    logic [DW-1:0]   merged;

    // Winner selection: lone requester always wins, the pointer breaks ties.
    always_comb begin
        any_req   = p0.req | p1.req;
        gnt       = (p0.req && p1.req) ? ptr_q : p1.req;
        win_we    = gnt ? p1.we    : p0.we;
        win_addr  = gnt ? p1.addr  : p0.addr;
        win_wdata = gnt ? p1.wdata : p0.wdata;
        win_be    = gnt ? p1.be    : p0.be;
    end

    // Byte merge of new store data over the word captured in RD.
    always_comb begin
        merged = '0;
        for (int i = 0; i < int'(NB); i++) begin
            merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : data_q[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and outputs; memory controls come only from state and latches.
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        p0.ack    = 1'b0;
        p1.ack    = 1'b0;
        p0.rdata  = '0;
        p1.rdata  = '0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    if (!win_we)                 state_d = RD;
                    else if (win_be == 4'b1111)  state_d = WR;
                    else if (win_be == 4'b0000)  state_d = RESP;
                    else                         state_d = RD;
                end
            end
            RD: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                mem_addr = addr_q;
                state_d  = we_q ? WR : RESP;
            end
            WR: begin
                busy      = 1'b1;
                mem_write = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = merged;
                state_d   = RESP;
            end
            RESP: begin
                busy    = 1'b1;
                state_d = IDLE;
                if (port_q) begin
                    p1.ack   = 1'b1;
                    p1.rdata = data_q;
                end else begin
                    p0.ack   = 1'b1;
                    p0.rdata = data_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Transaction latches, read-data capture and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= 1'b0;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        port_q  <= gnt;
                        we_q    <= win_we;
                        addr_q  <= win_addr;
                        wdata_q <= win_wdata;
                        be_q    <= win_be;
                    end
                end
                RD:      data_q <= mem_rdata;
                RESP:    ptr_q  <= ~ptr_q;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 64-word memory.
module tb_dmem_arbiter;
    localparam int unsigned AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          busy, mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    dmem_arbiter_if #(.AW(AW)) p0 ();
    dmem_arbiter_if #(.AW(AW)) p1 ();

    dmem_arbiter #(.AW(AW)) dut (
        .clk(clk), .rst(rst), .p0(p0), .p1(p1), .busy(busy),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    bit          loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[0] <= 32'd17;
            mem[1] <= 32'd9;
            mem[2] <= 32'd25;
            mem[3] <= 32'h11223344;
            loaded <= 1'b1;
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    logic [31:0] last_wdata = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_read)  rd_cnt = rd_cnt + 1;
        if (mem_write) begin
            wr_cnt = wr_cnt + 1;
            last_wdata = mem_wdata;
        end
    end

    typedef struct {
        int          port;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every ack must match the oldest expectation.
    always @(negedge clk) begin
        if (p0.ack || p1.ack) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack ack0=%0b ack1=%0b expected none", p0.ack, p1.ack);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_port", (p0.ack && p1.ack) ? 32'd3 : (p1.ack ? 32'd1 : 32'd0), 32'(mon_e.port));
                chk("ack_rdata", p1.ack ? p1.rdata : p0.rdata, mon_e.rdata);
                chk("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    task automatic push(input int port, input logic [31:0] rdata, input int c);
        exp_t e;
        e.port = port; e.rdata = rdata; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic drive(input int p, input bit we, input logic [AW-1:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        if (p == 0) begin
            p0.req = 1'b1; p0.we = we; p0.addr = addr; p0.wdata = wdata; p0.be = be;
        end else begin
            p1.req = 1'b1; p1.we = we; p1.addr = addr; p1.wdata = wdata; p1.be = be;
        end
    endtask

    task automatic release_all();
        p0.req = 1'b0; p1.req = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout pending=%0d expected 0", name, sb.size());
            sb.delete();
        end
        release_all();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack0"}, 32'(p0.ack), 32'h0);
        chk({tag, "_ack1"}, 32'(p1.ack), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_mem_read"}, 32'(mem_read), 32'h0);
        chk({tag, "_mem_write"}, 32'(mem_write), 32'h0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_rdata0"}, p0.rdata, 32'h0);
        chk({tag, "_rdata1"}, p1.rdata, 32'h0);
    endtask

    int n, rd0, wr0;

    initial begin
        p0.req = 0; p0.we = 0; p0.addr = '0; p0.wdata = '0; p0.be = '0;
        p1.req = 0; p1.we = 0; p1.addr = '0; p1.wdata = '0; p1.be = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Port 0 load of addr 1
        @(negedge clk); n = cyc; rd0 = rd_cnt; wr0 = wr_cnt;
        drive(0, 1'b0, 6'd1, 32'h0, 4'b0000);
        push(0, 32'd9, n + 2);
        wait_done("load1");
        chk("load1_rd_cycles", 32'(rd_cnt - rd0), 32'd1);
        chk("load1_wr_cycles", 32'(wr_cnt - wr0), 32'd0);

        // Port 1 full store to addr 5 (rdata holds last capture, 9)
        @(negedge clk); n = cyc; rd0 = rd_cnt; wr0 = wr_cnt;
        drive(1, 1'b1, 6'd5, 32'hDEADBEEF, 4'b1111);
        push(1, 32'd9, n + 2);
        wait_done("store_full");
        chk("store_full_rd_cycles", 32'(rd_cnt - rd0), 32'd0);
        chk("store_full_wr_cycles", 32'(wr_cnt - wr0), 32'd1);
        chk("store_full_mem5", mem[5], 32'hDEADBEEF);

        // Both ports held: 0,1,0,1 starting with port 0
        @(negedge clk); n = cyc;
        drive(0, 1'b0, 6'd0, 32'h0, 4'b0000);
        drive(1, 1'b0, 6'd2, 32'h0, 4'b0000);
        push(0, 32'd17, n + 2);
        push(1, 32'd25, n + 5);
        push(0, 32'd17, n + 8);
        push(1, 32'd25, n + 11);
        wait_done("contend4");

        // Port 0 load of addr 5 sees the stored word
        @(negedge clk); n = cyc;
        drive(0, 1'b0, 6'd5, 32'h0, 4'b0000);
        push(0, 32'hDEADBEEF, n + 2);
        wait_done("load5");

        // Partial store: RD then WR, merged word written
        @(negedge clk); n = cyc; rd0 = rd_cnt; wr0 = wr_cnt;
        drive(0, 1'b1, 6'd2, 32'hAABBCCDD, 4'b0110);
        push(0, 32'h00000019, n + 3);
        wait_done("store_part");
        chk("store_part_rd_cycles", 32'(rd_cnt - rd0), 32'd1);
        chk("store_part_wr_cycles", 32'(wr_cnt - wr0), 32'd1);
        chk("store_part_wdata", last_wdata, 32'h00BBCC19);
        chk("store_part_mem2", mem[2], 32'h00BBCC19);

        // be=0000 store: no memory access, ack next cycle
        @(negedge clk); n = cyc; rd0 = rd_cnt; wr0 = wr_cnt;
        drive(0, 1'b1, 6'd7, 32'h12345678, 4'b0000);
        push(0, 32'h00000019, n + 1);
        wait_done("store_be0");
        chk("store_be0_rd_cycles", 32'(rd_cnt - rd0), 32'd0);
        chk("store_be0_wr_cycles", 32'(wr_cnt - wr0), 32'd0);
        chk("store_be0_mem7", mem[7], 32'h0);

        // Pointer flipped to port 1: contention now serves 1 then 0
        @(negedge clk); n = cyc;
        drive(0, 1'b0, 6'd0, 32'h0, 4'b0000);
        drive(1, 1'b0, 6'd1, 32'h0, 4'b0000);
        push(1, 32'd9, n + 2);
        push(0, 32'd17, n + 5);
        wait_done("contend2");

        // Reset during WR of a partial store
        @(negedge clk);
        drive(0, 1'b1, 6'd3, 32'hFFFFFFFF, 4'b0011);
        @(negedge clk);
        @(negedge clk);
        chk("rst_wr_mem_write_before", 32'(mem_write), 32'h1);
        #1 rst = 1'b1;
        #1 chk_all_zero("rst_mid");
        release_all();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mem3_unchanged", mem[3], 32'h11223344);
        chk("rst_idle_busy", 32'(busy), 32'h0);

        // Fresh port 1 load after reset
        @(negedge clk); n = cyc;
        drive(1, 1'b0, 6'd3, 32'h0, 4'b0000);
        push(1, 32'h11223344, n + 2);
        wait_done("post_rst_load");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
